// File: rtl/trap_sequencer_if.sv
// Commit-side / CSR-port bundle for trap_sequencer.
// master = core/bench side, slave = the sequencer.
interface trap_sequencer_if #(parameter int XLEN = 64);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            ecall;
  logic            mret;
  logic            msip;
  logic            mtip;
  logic            mie_msie;
  logic            mie_mtie;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            trap_take;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            stall;
  logic            in_trap;

  modport master (
    output commit_valid, commit_pc, ecall, mret, msip, mtip, mie_msie, mie_mtie,
           mstatus, mtvec, mepc,
    input  trap_take, csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc,
           flush, stall, in_trap
  );

  modport slave (
    input  commit_valid, commit_pc, ecall, mret, msip, mtip, mie_msie, mie_mtie,
           mstatus, mtvec, mepc,
    output trap_take, csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc,
           flush, stall, in_trap
  );
endinterface

// File: rtl/trap_sequencer.sv
// Commit-boundary trap entry / mret sequencer driving the single CSR write port.
// Optional TRAP_VECTORED_EN: vectored interrupt redirect when mtvec[1:0]==2'b01.
module trap_sequencer #(
  parameter int XLEN = 64
) (
  input  logic           clk,
  input  logic           rst,
  trap_sequencer_if.slave bus
);

  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;

  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MSI   = {1'b1, (XLEN-1)'(3)};
  localparam logic [XLEN-1:0] CAUSE_MTI   = {1'b1, (XLEN-1)'(7)};

  typedef enum logic [2:0] {
    IDLE,
    S_EPC,
    S_CAUSE,
    S_STATUS,
    S_RSTATUS,
    S_REDIR
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pcL;
  logic [XLEN-1:0] causeL;
  logic [XLEN-1:0] statusL;
  logic [XLEN-1:0] tvecL;
  logic [XLEN-1:0] epcL;

  logic            csrWe;
  logic [11:0]     csrWaddr;
  logic [XLEN-1:0] csrWdata;
  logic            redirValid;
  logic [XLEN-1:0] redirPc;
  logic            flushR;
  logic            stallR;
  logic            inTrapR;

  logic            msiHit;
  logic            mtiHit;
  logic            trapTake;
  logic            takeMret;
  logic [XLEN-1:0] acceptCause;
  logic [XLEN-1:0] tvecBase;
  logic [XLEN-1:0] trapTarget;

  function automatic logic [XLEN-1:0] entryStatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] returnStatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Interrupts need the global MIE bit; ecall ignores it.
  assign msiHit = bus.msip & bus.mie_msie & bus.mstatus[3];
  assign mtiHit = bus.mtip & bus.mie_mtie & bus.mstatus[3];

  always_comb begin
    acceptCause = CAUSE_ECALL;
    takeMret    = 1'b0;
    if (bus.ecall)     acceptCause = CAUSE_ECALL;
    else if (msiHit)   acceptCause = CAUSE_MSI;
    else if (mtiHit)   acceptCause = CAUSE_MTI;
    else if (bus.mret) begin
      acceptCause = '0;
      takeMret    = 1'b1;
    end
  end

  assign trapTake = (state == IDLE) & bus.commit_valid &
                    (bus.ecall | msiHit | mtiHit | bus.mret);

  assign tvecBase = {tvecL[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Only interrupts vector; mode values 2'b10/2'b11 fall back to direct.
  assign trapTarget = (causeL[XLEN-1] && tvecL[1:0] == 2'b01)
                    ? tvecBase + {{(XLEN-8){1'b0}}, causeL[5:0], 2'b00}
                    : tvecBase;
`else
  logic unusedTvecMode;
  assign unusedTvecMode = ^tvecL[1:0];
  assign trapTarget     = tvecBase;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pcL        <= '0;
      causeL     <= '0;
      statusL    <= '0;
      tvecL      <= '0;
      epcL       <= '0;
      csrWe      <= 1'b0;
      csrWaddr   <= '0;
      csrWdata   <= '0;
      redirValid <= 1'b0;
      redirPc    <= '0;
      flushR     <= 1'b0;
      stallR     <= 1'b0;
      inTrapR    <= 1'b0;
    end else begin
      csrWe      <= 1'b0;
      csrWaddr   <= '0;
      csrWdata   <= '0;
      redirValid <= 1'b0;
      redirPc    <= '0;
      flushR     <= 1'b0;
      case (state)
        IDLE: begin
          if (trapTake) begin
            pcL     <= bus.commit_pc;
            causeL  <= acceptCause;
            statusL <= bus.mstatus;
            tvecL   <= bus.mtvec;
            epcL    <= bus.mepc;
            stallR  <= 1'b1;
            csrWe   <= 1'b1;
            if (takeMret) begin
              state    <= S_RSTATUS;
              csrWaddr <= ADDR_MSTATUS;
              csrWdata <= returnStatus(bus.mstatus);
            end else begin
              state    <= S_EPC;
              csrWaddr <= ADDR_MEPC;
              csrWdata <= bus.commit_pc;
            end
          end
        end
        S_EPC: begin
          state    <= S_CAUSE;
          csrWe    <= 1'b1;
          csrWaddr <= ADDR_MCAUSE;
          csrWdata <= causeL;
        end
        S_CAUSE: begin
          state    <= S_STATUS;
          csrWe    <= 1'b1;
          csrWaddr <= ADDR_MSTATUS;
          csrWdata <= entryStatus(statusL);
        end
        S_STATUS: begin
          state      <= S_REDIR;
          redirValid <= 1'b1;
          flushR     <= 1'b1;
          redirPc    <= trapTarget;
          inTrapR    <= 1'b1;
        end
        S_RSTATUS: begin
          state      <= S_REDIR;
          redirValid <= 1'b1;
          flushR     <= 1'b1;
          redirPc    <= epcL;
          inTrapR    <= 1'b0;
        end
        S_REDIR: begin
          state  <= IDLE;
          stallR <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          stallR <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trap_take      = trapTake;
  assign bus.csr_we         = csrWe;
  assign bus.csr_waddr      = csrWaddr;
  assign bus.csr_wdata      = csrWdata;
  assign bus.redirect_valid = redirValid;
  assign bus.redirect_pc    = redirPc;
  assign bus.flush          = flushR;
  assign bus.stall          = stallR;
  assign bus.in_trap        = inTrapR;

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle controller that takes traps and returns from them at the commit boundary of the NPC core.
- Arbitrates between ecall, machine software interrupt (MSI) and machine timer interrupt (MTI), and accepts mret.
- Drives the core's single CSR write port in sequence (mepc, mcause, mstatus), then issues one pipeline flush/redirect.
- Sits between the commit stage and the CSR file.

Parameters:
- XLEN, 64, datapath width for PC, CSR data and mcause.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- commit_valid  input  1  an instruction is at commit this cycle
- commit_pc  input  XLEN  PC of the committing instruction
- ecall  input  1  committing instruction is ecall (qualified by commit_valid)
- mret  input  1  committing instruction is mret (qualified by commit_valid)
- msip  input  1  software interrupt pending, level
- mtip  input  1  timer interrupt pending, level
- mie_msie  input  1  mie.MSIE
- mie_mtie  input  1  mie.MTIE
- mstatus  input  XLEN  current mstatus value
- mtvec  input  XLEN  current mtvec value
- mepc  input  XLEN  current mepc value
- trap_take  output  1  combinational; kills the committing instruction this cycle
- csr_we  output  1  CSR write strobe
- csr_waddr  output  12  CSR address: 0x341 mepc, 0x342 mcause, 0x300 mstatus
- csr_wdata  output  XLEN  CSR write data
- redirect_valid  output  1  one-cycle PC redirect pulse
- redirect_pc  output  XLEN  redirect target
- flush  output  1  pipeline flush, same cycle as redirect_valid
- stall  output  1  freezes fetch and commit while the sequencer is busy
- in_trap  output  1  set on trap entry, cleared on mret completion

Behaviour:
- Reset: state IDLE. csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc, flush, stall and in_trap are all 0.
  - Reset asserted mid-sequence aborts to IDLE. No remaining CSR writes are issued.
- Event qualification, IDLE only, requires commit_valid=1. Priority, highest first:
  1. ecall: always taken.
  2. MSI: msip & mie_msie & mstatus[3].
  3. MTI: mtip & mie_mtie & mstatus[3].
  4. mret.
  - Lower-priority events in the same cycle are dropped; pending interrupt levels are re-evaluated on return to IDLE.
- Accept cycle T0: trap_take=1 combinationally. These values are latched: commit_pc, cause, the mstatus snapshot, mtvec, and mepc (for mret).
  - Cause values: ecall 64'd11; MSI {1'b1, 63'd3}; MTI {1'b1, 63'd7}.
- Trap path (registered outputs, one state per cycle):
  - T1, S_EPC: csr_we=1, addr 0x341, data = latched PC.
  - T2, S_CAUSE: addr 0x342, data = cause.
  - T3, S_STATUS: addr 0x300, data = snapshot with MPIE(bit 7) = old MIE(bit 3), MIE = 0, MPP(bits 12:11) = 2'b11; all other bits unchanged. in_trap is set at the end of T3.
  - T4, S_REDIR: redirect_valid=1, flush=1, redirect_pc = {mtvec[XLEN-1:2], 2'b00}.
  - T5: back in IDLE.
- mret path:
  - T1, S_RSTATUS: addr 0x300, data = snapshot with MIE = old MPIE, MPIE = 1, MPP = 2'b11.
  - T2, S_REDIR: redirect_pc = latched mepc; in_trap is cleared.
  - T3: back in IDLE.
- stall: 1 from T1 through the S_REDIR cycle inclusive; 0 in IDLE.
- Events are ignored in every state except IDLE. No second trap can start until redirect completes.
- csr_we is high for exactly one cycle per write state, and csr_waddr/csr_wdata are 0 whenever csr_we=0.
- ecall while in_trap=1 is still taken (nested sync trap). Interrupts are masked by MIE=0, which trap entry guarantees.
- commit_valid=0 means nothing is taken, even with pending interrupts.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01 and the cause is an interrupt, redirect_pc = {mtvec[XLEN-1:2], 2'b00} + 4*cause[5:0]. ecall still uses the base address. mtvec[1:0] values 2'b10 and 2'b11 are treated as direct.
- Undefined: redirect is always the base address; mtvec[1:0] is ignored.

Test Plan:
- ecall at commit_pc=0x8000_0010, mtvec=0x8000_1000, mstatus=0x8 -> trap_take at T0. Then writes:
  - 0x341 = 0x8000_0010
  - 0x342 = 11
  - 0x300 = 0x1880
  - Then redirect to 0x8000_1000 at T4; in_trap=1; stall high T1–T4.
- mret after that trap, with mepc=0x8000_0014 and mstatus=0x1880 -> write 0x300 = 0x1888, redirect to 0x8000_0014 at T2, in_trap=0.
- mtip=1, mie_mtie=1, MIE=1, commit_pc=0x8000_0020 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0020. With MIE=0 -> no trap_take.
- ecall, msip and mtip asserted in the same cycle (all enabled) -> cause 11. MSI is taken next with mepc = the next commit_pc, and MTI only after MSI's mret.
- rst asserted during S_CAUSE -> all outputs 0 immediately. No mstatus write or redirect follows; in_trap=0.
- With TRAP_VECTORED_EN, mtvec=0x8000_1001 -> MTI redirects to 0x8000_101C, while ecall redirects to 0x8000_1000.
